// File: rtl/mult_pkg.sv
// Shared constants, state encoding and pair-count helper for the multiply job sequencer.
package mult_pkg;

  localparam logic [1:0] MODE_U8   = 2'd0;
  localparam logic [1:0] MODE_S8   = 2'd1;
  localparam logic [1:0] MODE_S16  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  localparam int unsigned MAX_PAIRS = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StIssue,
    StWait,
    StOut,
    StFin
  } state_e;

  // Index of the final pair; a request of 0 or anything above the maximum runs a full job.
  function automatic logic [3:0] last_index(input logic [4:0] n);
    if (n == 5'd0 || n >= 5'(MAX_PAIRS)) begin
      return 4'(MAX_PAIRS - 1);
    end
    return n[3:0] - 4'd1;
  endfunction

endpackage

// File: rtl/mult_operand_fmt.sv
// Mode-dependent operand slicing from a bank word and extension of the raw product.
module mult_operand_fmt
  import mult_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [15:0] word,
  input  logic [31:0] product,
  output logic [15:0] operand,
  output logic [31:0] result
);

  always_comb begin
    operand = {8'h00, word[7:0]};
    result  = {16'h0000, product[15:0]};
    case (mode)
      MODE_S8: begin
        operand = {{8{word[7]}}, word[7:0]};
        result  = {{16{product[15]}}, product[15:0]};
      end
      MODE_S16: begin
        operand = word;
        result  = product;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_job_sequencer.sv
// Fetches operand pairs from the bank, issues them to the shared multiplier and
// returns each product over a ready/valid port, with a start/busy/done job handshake.
module mult_job_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [4:0]        num_pairs,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_rdata,
  output logic              mul_valid,
  output logic [1:0]        mul_mode,
  output logic [15:0]       mul_a,
  output logic [15:0]       mul_b,
  input  logic [31:0]       mul_product,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [3:0]        res_index
);

  localparam int unsigned CntW = 3;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [3:0]        last_q;
  logic [CntW-1:0]   wait_q;
  logic [15:0]       b_q;
  logic [15:0]       fmt_operand;
  logic [31:0]       fmt_result;

  logic unused_rdata;
  assign unused_rdata = ^mem_rdata[63:16];

  mult_operand_fmt u_fmt (
    .mode    (mul_mode),
    .word    (mem_rdata[15:0]),
    .product (mul_product),
    .operand (fmt_operand),
    .result  (fmt_result)
  );

  // B only arrives on the read port during the issue cycle, so it bypasses its holding register.
  assign mul_b = (state_q == StIssue) ? fmt_operand : b_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      last_q    <= '0;
      wait_q    <= '0;
      b_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      mul_valid <= 1'b0;
      mul_mode  <= MODE_U8;
      mul_a     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_index <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      mul_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StRdA;
            busy      <= 1'b1;
            mul_mode  <= (mode == MODE_RSVD) ? MODE_U8 : mode;
            ptr_q     <= base_addr;
            last_q    <= last_index(num_pairs);
            res_index <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= base_addr;
          end
        end
        StRdA: begin
          state_q   <= StRdB;
          mem_rd_en <= 1'b1;
          mem_addr  <= ptr_q + ADDR_W'(1);
        end
        StRdB: begin
          state_q   <= StIssue;
          mul_a     <= fmt_operand;
          mul_valid <= 1'b1;
        end
        StIssue: begin
          state_q <= StWait;
          b_q     <= fmt_operand;
          wait_q  <= CntW'(MUL_LAT - 1);
        end
        StWait: begin
          if (wait_q == '0) begin
            state_q   <= StOut;
            res_data  <= fmt_result;
            res_valid <= 1'b1;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        StOut: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (res_index == last_q) begin
              state_q <= StFin;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_q   <= StRdA;
              ptr_q     <= ptr_q + ADDR_W'(2);
              res_index <= res_index + 4'd1;
              mem_rd_en <= 1'b1;
              mem_addr  <= ptr_q + ADDR_W'(2);
            end
          end
        end
        StFin: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Scoreboard bench: jobs push expected addresses, operands and results; a monitor checks them.
module tb_mult_job_sequencer;

  localparam int ADDR_W  = 5;
  localparam int MUL_LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [4:0]  base_addr = 5'd0;
  logic [4:0]  num_pairs = 5'd0;
  logic        busy, done, mem_rd_en, mul_valid, res_valid;
  logic        res_ready = 1'b0;
  logic [4:0]  mem_addr;
  logic [63:0] mem_rdata;
  logic [1:0]  mul_mode;
  logic [15:0] mul_a, mul_b;
  logic [31:0] mul_product, res_data;
  logic [3:0]  res_index;

  always #5 clock = ~clock;

  mult_job_sequencer #(.ADDR_W(ADDR_W), .MUL_LAT(MUL_LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
    .num_pairs(num_pairs), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mul_valid(mul_valid), .mul_mode(mul_mode),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_index(res_index)
  );

  // Operand bank with one-cycle read latency.
  logic [63:0] bank [32];
  always @(posedge clock) if (mem_rd_en) mem_rdata <= bank[mem_addr];

  // Fixed-latency multiplier; garbage when nothing was issued so mistimed captures show up.
  function automatic logic [31:0] mult_model(input logic [1:0] m, input logic [15:0] a,
                                             input logic [15:0] b);
    logic signed [31:0] sa, sb;
    if (m == 2'd0) return {16'h0, a} * {16'h0, b};
    sa = 32'(signed'(a));
    sb = 32'(signed'(b));
    return 32'(sa * sb);
  endfunction

  logic [31:0] mpipe [MUL_LAT];
  always @(posedge clock) begin
    mpipe[0] <= mul_valid ? mult_model(mul_mode, mul_a, mul_b) : 32'hDEAD_BEEF;
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_product = mpipe[MUL_LAT-1];

  typedef struct { logic [31:0] data; logic [3:0] idx; } res_t;
  typedef struct { logic [15:0] a; logic [15:0] b; logic [1:0] m; } op_t;
  res_t       res_q[$];
  op_t        op_q[$];
  logic [4:0] addr_q[$];

  int n_checks = 0;
  int n_err = 0;
  int n_done = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: event not expected/not reached at cycle %0d", name, cyc);
  endtask

  function automatic int slice_op(input int m, input logic [63:0] w);
    if (m == 1) return int'(signed'(w[7:0]));
    if (m == 2) return int'(signed'(w[15:0]));
    return int'(w[7:0]);
  endfunction

  // Reference: pair i of a job reads A at base+2i and B right after it, modulo 32.
  task automatic push_job(input int m_in, input int base, input int np);
    int m, n;
    m = (m_in == 3) ? 0 : m_in;
    n = (np == 0 || np > 16) ? 16 : np;
    for (int i = 0; i < n; i++) begin
      int aa, ba, a, b;
      logic [31:0] p;
      res_t r;
      op_t  o;
      aa = (base + 2 * i) % 32;
      ba = (aa + 1) % 32;
      a  = slice_op(m, bank[aa]);
      b  = slice_op(m, bank[ba]);
      p  = 32'(a * b);
      addr_q.push_back(5'(aa));
      addr_q.push_back(5'(ba));
      o.a = 16'(a); o.b = 16'(b); o.m = 2'(m);
      op_q.push_back(o);
      r.idx  = 4'(i);
      r.data = (m == 2) ? p : (m == 1) ? {{16{p[15]}}, p[15:0]} : {16'h0, p[15:0]};
      res_q.push_back(r);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  bit          rv_prev, stall_prev, busy_prev, mv_pend, rv_pend;
  logic [31:0] data_prev;
  logic [3:0]  idx_prev;
  int          acc_cyc, last_acc_cyc;

  always @(negedge clock) begin
    if (!reset) begin
      rv_prev = 0; stall_prev = 0; busy_prev = 0; mv_pend = 0; rv_pend = 0;
    end else begin
      if (busy && !busy_prev) begin
        acc_cyc = cyc; mv_pend = 1; rv_pend = 1;
        chk("rd_at_accept", mem_rd_en, 1);
      end
      if (mem_rd_en) begin
        chk("rd_while_result", res_valid, 0);
        if (addr_q.size() == 0) fail("rd_unexpected");
        else chk("rd_addr", mem_addr, addr_q.pop_front());
      end
      if (mul_valid) begin
        if (mv_pend) begin chk("issue_latency", cyc - acc_cyc, 2); mv_pend = 0; end
        if (op_q.size() == 0) fail("issue_unexpected");
        else begin
          op_t o;
          o = op_q.pop_front();
          chk("mul_a", mul_a, o.a);
          chk("mul_b", mul_b, o.b);
          chk("mul_mode", mul_mode, o.m);
        end
      end
      if (res_valid) begin
        if (!rv_prev) begin
          if (rv_pend) chk("result_latency", cyc - acc_cyc, 3 + MUL_LAT);
          else chk("pair_period", cyc - last_acc_cyc, 4 + MUL_LAT);
          rv_pend = 0;
        end
        if (stall_prev) begin
          chk("hold_data", res_data, data_prev);
          chk("hold_index", res_index, idx_prev);
        end
        chk("busy_during_result", busy, 1);
        if (res_ready) begin
          if (res_q.size() == 0) fail("result_unexpected");
          else begin
            res_t r;
            r = res_q.pop_front();
            chk("res_data", res_data, r.data);
            chk("res_index", res_index, r.idx);
          end
          last_acc_cyc = cyc;
        end
      end else if (stall_prev) begin
        fail("hold_valid_dropped");
      end
      if (done) begin
        n_done++;
        chk("done_after_accept", cyc - last_acc_cyc, 1);
        chk("busy_low_at_done", busy, 0);
      end
      stall_prev = res_valid && !res_ready;
      data_prev  = res_data;
      idx_prev   = res_index;
      rv_prev    = res_valid;
      busy_prev  = busy;
    end
  end

  task automatic check_reset_values();
    chk("rst_busy", busy, 0);          chk("rst_done", done, 0);
    chk("rst_rd_en", mem_rd_en, 0);    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_res_valid", res_valid, 0); chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mul_a", mul_a, 0);        chk("rst_mul_b", mul_b, 0);
    chk("rst_mul_mode", mul_mode, 0);  chk("rst_res_data", res_data, 0);
    chk("rst_res_index", res_index, 0);
  endtask

  task automatic fill_bank_random();
    for (int i = 0; i < 32; i++) bank[i] = {$urandom, $urandom};
  endtask

  // hold: ready is kept low for this many cycles once the first result appears.
  task automatic run_job(input int m, input int base, input int np, input bit extra,
                         input int stall_pct, input int hold);
    int d0;
    bit extra_done;
    int h;
    d0 = n_done;
    extra_done = 0;
    h = hold;
    push_job(m, base, np);
    @(posedge clock); #1;
    start = 1; mode = 2'(m); base_addr = 5'(base); num_pairs = 5'(np); res_ready = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #1;
      start = 0;
      if (n_done != d0) break;
      mode = 2'($urandom); base_addr = 5'($urandom); num_pairs = 5'($urandom);
      if (h > 0 && res_valid) begin
        res_ready = 0;
        h--;
      end else begin
        res_ready = ($urandom_range(0, 99) >= stall_pct);
      end
      // A start coinciding with a result accept must be ignored.
      if (extra && !extra_done && res_valid && res_ready && res_index >= 4'd3) begin
        start = 1;
        extra_done = 1;
      end
    end
    res_ready = 0;
    chk("done_once", n_done - d0, 1);
    repeat (3) @(posedge clock);
    #1;
    chk("done_no_repeat", n_done - d0, 1);
    chk("results_left", res_q.size(), 0);
    chk("issues_left", op_q.size(), 0);
    chk("reads_left", addr_q.size(), 0);
  endtask

  initial begin
    int n0;
    for (int i = 0; i < 32; i++) bank[i] = 64'h0;
    #1;
    check_reset_values();
    repeat (3) @(posedge clock);
    #1 reset = 1;

    bank[0] = 64'hFF; bank[1] = 64'h02; bank[2] = 64'h10; bank[3] = 64'h10;
    run_job(0, 0, 2, 0, 0, 0);

    bank[4] = 64'hFF; bank[5] = 64'h03;
    run_job(1, 4, 1, 0, 0, 5);

    bank[31] = 64'h8000; bank[0] = 64'h0002;
    run_job(2, 31, 1, 0, 0, 0);

    fill_bank_random();
    run_job($urandom_range(0, 3), $urandom_range(0, 31), 0, 1, 20, 0);

    // Reset in the middle of the multiplier wait.
    fill_bank_random();
    push_job(2, 10, 3);
    @(posedge clock); #1;
    start = 1; mode = 2'd2; base_addr = 5'd10; num_pairs = 5'd3; res_ready = 1;
    @(posedge clock); #1;
    start = 0;
    for (int c = 0; c < 20 && !mul_valid; c++) begin
      @(posedge clock); #1;
    end
    if (!mul_valid) fail("reach_issue");
    @(posedge clock); #1;
    n0 = n_done;
    reset = 0;
    #1;
    check_reset_values();
    res_q.delete(); op_q.delete(); addr_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1;
    repeat (12) @(posedge clock);
    #1;
    chk("no_done_after_reset", n_done - n0, 0);
    chk("no_busy_after_reset", busy, 0);
    run_job(2, 10, 3, 0, 0, 0);

    for (int j = 0; j < 12; j++) begin
      fill_bank_random();
      run_job($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
              1, 30, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
